// File: rtl/axis_async_fifo.sv
// rtl/axis_async_fifo.sv - AXI4-Stream FIFO with optional frame commit/drop, single clock
// Sideband fields are stored raw and replaced by constants on output when disabled.

module axis_async_fifo #(
  parameter int DEPTH          = 4096,
  parameter int DATA_WIDTH     = 8,
  parameter int KEEP_ENABLE    = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH     = (DATA_WIDTH + 7) / 8,
  parameter int LAST_ENABLE    = 1,
  parameter int ID_ENABLE      = 0,
  parameter int ID_WIDTH       = 8,
  parameter int DEST_ENABLE    = 0,
  parameter int DEST_WIDTH     = 8,
  parameter int USER_ENABLE    = 0,
  parameter int USER_WIDTH     = 1,
  parameter int RAM_PIPELINE   = 1,
  parameter int FRAME_FIFO     = 0,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1,
  parameter int DROP_BAD_FRAME = 0,
  parameter int DROP_WHEN_FULL = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  s_pause_req,
  input  logic                  m_pause_req,
  output logic                  s_status_overflow,
  output logic                  s_status_bad_frame,
  output logic                  s_status_good_frame,
  output logic                  m_status_overflow,
  output logic                  m_status_bad_frame,
  output logic                  m_status_good_frame
);

  localparam int AW   = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int PIPE = RAM_PIPELINE + 1;
  localparam int KO   = DATA_WIDTH;
  localparam int LO   = KO + KEEP_WIDTH;
  localparam int IO   = LO + 1;
  localparam int DO   = IO + ID_WIDTH;
  localparam int UO   = DO + DEST_WIDTH;
  localparam int W    = UO + USER_WIDTH;

  localparam bit FRAME    = (FRAME_FIFO != 0);
  localparam bit DROP_BAD = (DROP_BAD_FRAME != 0);
  localparam bit DROP_FUL = (DROP_WHEN_FULL != 0);
  localparam bit KEEP_EN  = (KEEP_ENABLE != 0);
  localparam bit LAST_EN  = (LAST_ENABLE != 0);
  localparam bit ID_EN    = (ID_ENABLE != 0);
  localparam bit DEST_EN  = (DEST_ENABLE != 0);
  localparam bit USER_EN  = (USER_ENABLE != 0);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] CAP     = {1'b1, {AW{1'b0}}};

  logic [AW:0]   wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d, out_ptr_q, out_ptr_d;
  logic          drop_q, drop_d, s_frame_q, s_frame_d, m_frame_q, m_frame_d;
  logic          ovf_q, ovf_d, bad_q, bad_d, good_q, good_d;
  logic          ready_en_q;
  logic [PIPE-1:0] valid_q, valid_d, take;

  logic [W-1:0]  mem [0:(1<<AW)-1];
  logic [W-1:0]  pipe_q [PIPE];
  logic [W-1:0]  s_word, out_word;

  logic s_last, out_last, full, empty, lossy, bad_frame;
  logic s_paused, m_paused, s_fire, pop, mem_we;

  assign s_word    = {s_axis_tuser, s_axis_tdest, s_axis_tid, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  assign out_word  = pipe_q[PIPE-1];
  assign s_last    = LAST_EN ? s_axis_tlast : 1'b1;
  assign out_last  = LAST_EN ? out_word[LO] : 1'b1;

  // Occupancy counts beats still in the output pipeline, so capacity is exact DEPTH.
  assign full      = ((wr_ptr_q - out_ptr_q) == CAP);
  assign empty     = (rd_ptr_q == commit_ptr_q);
  assign lossy     = FRAME && (DROP_FUL || (commit_ptr_q == out_ptr_q));
  assign bad_frame = ((s_axis_tuser & USER_BAD_FRAME_MASK) == (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK));

  assign s_paused      = s_pause_req && !s_frame_q;
  assign m_paused      = m_pause_req && !m_frame_q;
  assign s_axis_tready = ready_en_q && !s_paused && (!full || drop_q || lossy);
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = valid_q[PIPE-1] && !m_paused;
  assign pop           = m_axis_tvalid && m_axis_tready;

  assign m_axis_tdata = out_word[DATA_WIDTH-1:0];
  assign m_axis_tkeep = KEEP_EN ? out_word[KO +: KEEP_WIDTH] : {KEEP_WIDTH{1'b1}};
  assign m_axis_tlast = out_last;
  assign m_axis_tid   = ID_EN   ? out_word[IO +: ID_WIDTH]   : '0;
  assign m_axis_tdest = DEST_EN ? out_word[DO +: DEST_WIDTH] : '0;
  assign m_axis_tuser = USER_EN ? out_word[UO +: USER_WIDTH] : '0;

  assign s_status_overflow   = ovf_q;
  assign s_status_bad_frame  = bad_q;
  assign s_status_good_frame = good_q;
  assign m_status_overflow   = ovf_q;
  assign m_status_bad_frame  = bad_q;
  assign m_status_good_frame = good_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    drop_d       = drop_q;
    s_frame_d    = s_frame_q;
    ovf_d        = 1'b0;
    bad_d        = 1'b0;
    good_d       = 1'b0;
    mem_we       = 1'b0;
    if (s_fire) begin
      s_frame_d = !s_last;
      if (drop_q) begin
        if (s_last) begin
          drop_d = 1'b0;
          ovf_d  = 1'b1;
        end
      end else if (full) begin
        // Only reachable in frame mode: abandon the partial frame and swallow the rest.
        wr_ptr_d = commit_ptr_q;
        if (s_last) ovf_d = 1'b1;
        else        drop_d = 1'b1;
      end else begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (!FRAME) begin
          commit_ptr_d = wr_ptr_q + PTR_ONE;
        end else if (s_last) begin
          if (DROP_BAD && bad_frame) begin
            wr_ptr_d = commit_ptr_q;
            bad_d    = 1'b1;
          end else begin
            commit_ptr_d = wr_ptr_q + PTR_ONE;
            good_d       = 1'b1;
          end
        end
      end
    end
  end

  // A stage reloads when it is empty or its content moves on; this ripples back to the RAM read.
  always_comb begin
    logic t;
    take = '0;
    t = !valid_q[PIPE-1] || pop;
    take[PIPE-1] = t;
    for (int i = PIPE - 2; i >= 0; i--) begin
      t = !valid_q[i] || t;
      take[i] = t;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (take[0]) valid_d[0] = !empty;
    for (int i = 1; i < PIPE; i++) begin
      if (take[i]) valid_d[i] = valid_q[i-1];
    end
    rd_ptr_d  = (take[0] && !empty) ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    out_ptr_d = pop ? out_ptr_q + PTR_ONE : out_ptr_q;
    m_frame_d = pop ? !out_last : m_frame_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= s_word;
    if (take[0]) pipe_q[0] <= mem[rd_ptr_q[AW-1:0]];
    for (int i = 1; i < PIPE; i++) begin
      if (take[i]) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      out_ptr_q    <= '0;
      drop_q       <= 1'b0;
      s_frame_q    <= 1'b0;
      m_frame_q    <= 1'b0;
      ovf_q        <= 1'b0;
      bad_q        <= 1'b0;
      good_q       <= 1'b0;
      ready_en_q   <= 1'b0;
      valid_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_ptr_q    <= out_ptr_d;
      drop_q       <= drop_d;
      s_frame_q    <= s_frame_d;
      m_frame_q    <= m_frame_d;
      ovf_q        <= ovf_d;
      bad_q        <= bad_d;
      good_q       <= good_d;
      ready_en_q   <= 1'b1;
      valid_q      <= valid_d;
    end
  end

endmodule

// File: tb/tb_axis_async_fifo.sv
// tb/tb_axis_async_fifo.sv - scoreboard bench for axis_async_fifo (stream and frame instances)

module tb_axis_async_fifo;

  logic clk;
  logic rst_n;

  logic [7:0] a_s_tdata, a_m_tdata, a_s_tid, a_m_tid, a_s_tdest, a_m_tdest;
  logic [0:0] a_s_tkeep, a_m_tkeep, a_s_tuser, a_m_tuser;
  logic a_s_tvalid, a_s_tready, a_s_tlast, a_m_tvalid, a_m_tready, a_m_tlast;
  logic a_ovf, a_bad, a_good, a_movf, a_mbad, a_mgood;

  logic [7:0] b_s_tdata, b_m_tdata, b_s_tid, b_m_tid, b_s_tdest, b_m_tdest;
  logic [0:0] b_s_tkeep, b_m_tkeep, b_s_tuser, b_m_tuser;
  logic b_s_tvalid, b_s_tready, b_s_tlast, b_m_tvalid, b_m_tready, b_m_tlast;
  logic b_ovf, b_bad, b_good, b_movf, b_mbad, b_mgood;

  int n_checks = 0;
  int n_fail   = 0;
  int b_good_cnt = 0, b_bad_cnt = 0, b_mbad_cnt = 0, b_pop_cnt = 0;

  logic [8:0] a_exp_q[$];
  logic [8:0] b_exp_q[$];
  logic [8:0] b_pend_q[$];

  axis_async_fifo #(.DEPTH(4), .DATA_WIDTH(8), .RAM_PIPELINE(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(a_s_tdata), .s_axis_tkeep(a_s_tkeep), .s_axis_tvalid(a_s_tvalid),
    .s_axis_tready(a_s_tready), .s_axis_tlast(a_s_tlast), .s_axis_tid(a_s_tid),
    .s_axis_tdest(a_s_tdest), .s_axis_tuser(a_s_tuser),
    .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tvalid(a_m_tvalid),
    .m_axis_tready(a_m_tready), .m_axis_tlast(a_m_tlast), .m_axis_tid(a_m_tid),
    .m_axis_tdest(a_m_tdest), .m_axis_tuser(a_m_tuser),
    .s_pause_req(1'b0), .m_pause_req(1'b0),
    .s_status_overflow(a_ovf), .s_status_bad_frame(a_bad), .s_status_good_frame(a_good),
    .m_status_overflow(a_movf), .m_status_bad_frame(a_mbad), .m_status_good_frame(a_mgood)
  );

  axis_async_fifo #(.DEPTH(8), .DATA_WIDTH(8), .RAM_PIPELINE(1), .FRAME_FIFO(1),
                    .DROP_BAD_FRAME(1), .USER_ENABLE(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(b_s_tdata), .s_axis_tkeep(b_s_tkeep), .s_axis_tvalid(b_s_tvalid),
    .s_axis_tready(b_s_tready), .s_axis_tlast(b_s_tlast), .s_axis_tid(b_s_tid),
    .s_axis_tdest(b_s_tdest), .s_axis_tuser(b_s_tuser),
    .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
    .m_axis_tready(b_m_tready), .m_axis_tlast(b_m_tlast), .m_axis_tid(b_m_tid),
    .m_axis_tdest(b_m_tdest), .m_axis_tuser(b_m_tuser),
    .s_pause_req(1'b0), .m_pause_req(1'b0),
    .s_status_overflow(b_ovf), .s_status_bad_frame(b_bad), .s_status_good_frame(b_good),
    .m_status_overflow(b_movf), .m_status_bad_frame(b_mbad), .m_status_good_frame(b_mgood)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_m_tvalid && a_m_tready) begin
        if (a_exp_q.size() == 0) check("a_unexpected_beat", {23'd0, a_m_tlast, a_m_tdata}, 32'h1ff);
        else check("a_beat", {23'd0, a_m_tlast, a_m_tdata}, {23'd0, a_exp_q.pop_front()});
      end
      if (a_s_tvalid && a_s_tready) a_exp_q.push_back({a_s_tlast, a_s_tdata});

      if (b_m_tvalid && b_m_tready) begin
        b_pop_cnt++;
        if (b_exp_q.size() == 0) check("b_unexpected_beat", {23'd0, b_m_tlast, b_m_tdata}, 32'h1ff);
        else check("b_beat", {23'd0, b_m_tlast, b_m_tdata}, {23'd0, b_exp_q.pop_front()});
      end
      if (b_s_tvalid && b_s_tready) begin
        b_pend_q.push_back({b_s_tlast, b_s_tdata});
        if (b_s_tlast) begin
          if (b_s_tuser[0] != 1'b1) begin
            while (b_pend_q.size() != 0) b_exp_q.push_back(b_pend_q.pop_front());
          end
          b_pend_q.delete();
        end
      end
      if (b_good) b_good_cnt++;
      if (b_bad)  b_bad_cnt++;
      if (b_mbad) b_mbad_cnt++;
    end
  end

  task automatic drain_a(input string tag);
    int n = 0;
    while (a_exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check(tag, a_exp_q.size(), 0);
  endtask

  task automatic drain_b(input string tag);
    int n = 0;
    while (b_exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check(tag, b_exp_q.size(), 0);
  endtask

  task automatic send_b(input logic [7:0] d, input logic l, input logic u);
    int n = 0;
    b_s_tdata = d; b_s_tlast = l; b_s_tuser = u; b_s_tvalid = 1'b1;
    while (!b_s_tready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("b_send_timeout", n, 0);
    step();
    b_s_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    check("watchdog", 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i, cyc;
    logic acc;
    rst_n = 1'b0;
    a_s_tdata = '0; a_s_tkeep = '1; a_s_tvalid = 1'b0; a_s_tlast = 1'b0;
    a_s_tid = '0; a_s_tdest = '0; a_s_tuser = '0; a_m_tready = 1'b0;
    b_s_tdata = '0; b_s_tkeep = '1; b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
    b_s_tid = '0; b_s_tdest = '0; b_s_tuser = '0; b_m_tready = 1'b0;

    repeat (2) step();
    check("rst_a_tready", a_s_tready, 0);
    check("rst_a_tvalid", a_m_tvalid, 0);
    check("rst_b_tready", b_s_tready, 0);
    rst_n = 1'b1;
    check("release_tready_before_edge", a_s_tready, 0);
    step();
    check("release_tready_after_edge", a_s_tready, 1);
    check("release_b_tready", b_s_tready, 1);

    // single beat latency
    a_m_tready = 1'b1;
    a_s_tdata = 8'hA5; a_s_tlast = 1'b1; a_s_tvalid = 1'b1;
    step();
    a_s_tvalid = 1'b0;
    check("lat_edge0", a_m_tvalid, 0);
    step();
    check("lat_edge1", a_m_tvalid, 0);
    step();
    check("lat_edge2", a_m_tvalid, 1);
    check("lat_data", a_m_tdata, 8'hA5);
    check("lat_last", a_m_tlast, 1);
    step();
    step();
    check("single_empty", a_m_tvalid, 0);

    // fill to DEPTH, then free one slot
    a_m_tready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_s_tdata = 8'h10 + 8'(k); a_s_tlast = 1'b1; a_s_tvalid = 1'b1;
      check("fill_ready", a_s_tready, 1);
      step();
    end
    a_s_tdata = 8'h14;
    check("full_tready", a_s_tready, 0);
    step();
    check("full_hold", a_s_tready, 0);
    check("stall_valid", a_m_tvalid, 1);
    check("stall_data", a_m_tdata, 8'h10);
    a_m_tready = 1'b1;
    step();
    a_m_tready = 1'b0;
    check("freed_tready", a_s_tready, 1);
    step();
    a_s_tvalid = 1'b0;
    check("refull_tready", a_s_tready, 0);
    a_m_tready = 1'b1;
    drain_a("fill_drain");

    // ten beats with random backpressure
    i = 0; cyc = 0;
    while (i < 10 && cyc < 300) begin
      a_s_tvalid = 1'b1; a_s_tdata = 8'(i); a_s_tlast = (i == 9);
      a_m_tready = 1'($urandom_range(0, 1));
      acc = a_s_tready;
      step();
      if (acc) i++;
      cyc++;
    end
    a_s_tvalid = 1'b0;
    check("random_sent", i, 10);
    a_m_tready = 1'b1;
    drain_a("random_drain");

    // reset with content stored
    a_m_tready = 1'b0;
    a_s_tdata = 8'h61; a_s_tlast = 1'b0; a_s_tvalid = 1'b1;
    step();
    a_s_tdata = 8'h62; a_s_tlast = 1'b1;
    step();
    a_s_tvalid = 1'b0;
    repeat (3) step();
    check("prereset_valid", a_m_tvalid, 1);
    rst_n = 1'b0;
    #1;
    check("reset_valid_now", a_m_tvalid, 0);
    check("reset_tready_now", a_s_tready, 0);
    a_exp_q.delete();
    b_exp_q.delete();
    b_pend_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    a_m_tready = 1'b1;
    repeat (4) step();
    check("post_reset_empty", a_m_tvalid, 0);
    check("post_reset_tready", a_s_tready, 1);

    // frame mode: output held until tlast, good frame
    b_m_tready = 1'b1;
    send_b(8'h21, 1'b0, 1'b0);
    check("frame_hold0", b_m_tvalid, 0);
    send_b(8'h22, 1'b0, 1'b0);
    repeat (4) step();
    check("frame_hold1", b_m_tvalid, 0);
    send_b(8'h23, 1'b1, 1'b0);
    step();
    check("frame_commit_wait", b_m_tvalid, 0);
    step();
    check("frame_commit_valid", b_m_tvalid, 1);
    drain_b("frame_drain");
    repeat (2) step();
    check("good_pulses", b_good_cnt, 1);
    check("bad_none", b_bad_cnt, 0);

    // bad frame dropped, following frame intact
    send_b(8'h31, 1'b0, 1'b0);
    send_b(8'h32, 1'b0, 1'b0);
    send_b(8'h33, 1'b1, 1'b1);
    repeat (6) step();
    check("bad_no_output", b_m_tvalid, 0);
    check("bad_pulses", b_bad_cnt, 1);
    check("bad_m_pulses", b_mbad_cnt, 1);
    check("bad_no_good", b_good_cnt, 1);
    send_b(8'h41, 1'b0, 1'b0);
    send_b(8'h42, 1'b1, 1'b0);
    drain_b("after_bad_drain");
    repeat (2) step();
    check("good_pulses2", b_good_cnt, 2);
    check("b_beats_out", b_pop_cnt, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
